// File: rtl/mem_bus_arbiter_if.sv
// Handshake bundle for mem_bus_arbiter: instruction-fetch port, data port
// and the shared memory bus. The master modport is the environment
// (requesters plus bus responder); the slave modport is the arbiter.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = 8
) ();
    // instruction fetch port
    logic              i_req_valid;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_resp_valid;
    logic [DATA_W-1:0] i_resp_data;
    // MEM-stage data port
    logic              d_req_valid;
    logic              d_req_write;
    logic [ADDR_W-1:0] d_req_addr;
    logic [STRB_W-1:0] d_req_strobe;
    logic [DATA_W-1:0] d_req_wdata;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_resp_data;
    logic              resp_err;
    // shared memory bus
    logic              bus_valid;
    logic              bus_write;
    logic [ADDR_W-1:0] bus_addr;
    logic [STRB_W-1:0] bus_strobe;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ready;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output i_req_valid, i_req_addr,
        input  i_resp_valid, i_resp_data,
        output d_req_valid, d_req_write, d_req_addr, d_req_strobe, d_req_wdata,
        input  d_resp_valid, d_resp_data, resp_err,
        input  bus_valid, bus_write, bus_addr, bus_strobe, bus_wdata,
        output bus_ready, bus_rdata
    );

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_resp_valid, i_resp_data,
        input  d_req_valid, d_req_write, d_req_addr, d_req_strobe, d_req_wdata,
        output d_resp_valid, d_resp_data, resp_err,
        output bus_valid, bus_write, bus_addr, bus_strobe, bus_wdata,
        input  bus_ready, bus_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between instruction fetch (I) and
// the MEM-stage data port (D). One transaction in flight at a time:
// IDLE (grant) -> BUSY (hold bus) -> RESP (one-cycle completion pulse).
// D wins ties; after STARVE_LIMIT consecutive D grants with I waiting,
// I is forced through.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a bus transaction
// after TIMEOUT_CYC cycles without bus_ready (completion flagged by resp_err).
module mem_bus_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STRB_W       = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic             clk,
    input  logic             reset,
    mem_bus_arbiter_if.slave bus_if
);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_grant_d;
    logic                w_grant_i;
    logic                w_done;
    logic                w_abort;
    logic                w_wait_expired;

    logic                r_bus_valid;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [STRB_W-1:0]   r_strobe;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_owner_d;
    logic                r_i_resp_valid;
    logic                r_d_resp_valid;
    logic [DATA_W-1:0]   r_i_resp_data;
    logic [DATA_W-1:0]   r_d_resp_data;
    logic [STARVE_W-1:0] r_starve_cnt;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT_CYC);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_resp_err;

    assign w_wait_expired = (r_wait_cnt == TIMEOUT_V);

    // Count BUSY cycles without bus_ready; restart whenever a new grant is made.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else if (w_grant_d || w_grant_i) begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else if ((r_state == ST_BUSY) && !bus_if.bus_ready && !w_wait_expired) begin
            r_wait_cnt <= r_wait_cnt + WAIT_ONE;
        end
    end

    // Error flag accompanies the completion pulse of an aborted transaction only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_err <= 1'b0;
        end else begin
            r_resp_err <= w_abort;
        end
    end

    assign bus_if.resp_err = r_resp_err;
`else
    assign w_wait_expired  = 1'b0;
    assign bus_if.resp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: grant choice in IDLE, completion/abort detection in BUSY.
    always_comb begin
        w_next_state = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus_if.d_req_valid &&
                    !(bus_if.i_req_valid && (r_starve_cnt == STARVE_MAX))) begin
                    w_grant_d    = 1'b1;
                    w_next_state = ST_BUSY;
                end else if (bus_if.i_req_valid) begin
                    w_grant_i    = 1'b1;
                    w_next_state = ST_BUSY;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // a ready in the timeout cycle still completes normally
                if (bus_if.bus_ready) begin
                    w_done       = 1'b1;
                    w_next_state = ST_RESP;
                end else if (w_wait_expired) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request capture at grant, bus hold while BUSY, response latch and pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus_valid    <= 1'b0;
            r_write        <= 1'b0;
            r_addr         <= {ADDR_W{1'b0}};
            r_strobe       <= {STRB_W{1'b0}};
            r_wdata        <= {DATA_W{1'b0}};
            r_owner_d      <= 1'b0;
            r_i_resp_valid <= 1'b0;
            r_d_resp_valid <= 1'b0;
            r_i_resp_data  <= {DATA_W{1'b0}};
            r_d_resp_data  <= {DATA_W{1'b0}};
        end else begin
            r_i_resp_valid <= 1'b0;
            r_d_resp_valid <= 1'b0;
            if (w_grant_d) begin
                r_bus_valid <= 1'b1;
                r_owner_d   <= 1'b1;
                r_write     <= bus_if.d_req_write;
                r_addr      <= bus_if.d_req_addr;
                // loads never carry byte enables onto the bus
                r_strobe    <= bus_if.d_req_write ? bus_if.d_req_strobe : {STRB_W{1'b0}};
                r_wdata     <= bus_if.d_req_wdata;
            end else if (w_grant_i) begin
                r_bus_valid <= 1'b1;
                r_owner_d   <= 1'b0;
                r_write     <= 1'b0;
                r_addr      <= bus_if.i_req_addr;
                r_strobe    <= {STRB_W{1'b0}};
                r_wdata     <= {DATA_W{1'b0}};
            end
            if (w_done || w_abort) begin
                r_bus_valid <= 1'b0;
                if (r_owner_d) begin
                    r_d_resp_valid <= 1'b1;
                    r_d_resp_data  <= (r_write || w_abort) ? {DATA_W{1'b0}} : bus_if.bus_rdata;
                end else begin
                    r_i_resp_valid <= 1'b1;
                    r_i_resp_data  <= w_abort ? {DATA_W{1'b0}} : bus_if.bus_rdata;
                end
            end
        end
    end

    // Starvation counter: consecutive D grants that left a waiting I behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= {STARVE_W{1'b0}};
        end else if (w_grant_d && bus_if.i_req_valid) begin
            if (r_starve_cnt != STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + STARVE_ONE;
            end
        end else if (w_grant_d || w_grant_i) begin
            r_starve_cnt <= {STARVE_W{1'b0}};
        end
    end

    assign bus_if.bus_valid    = r_bus_valid;
    assign bus_if.bus_write    = r_write;
    assign bus_if.bus_addr     = r_addr;
    assign bus_if.bus_strobe   = r_strobe;
    assign bus_if.bus_wdata    = r_wdata;
    assign bus_if.i_resp_valid = r_i_resp_valid;
    assign bus_if.i_resp_data  = r_i_resp_data;
    assign bus_if.d_resp_valid = r_d_resp_valid;
    assign bus_if.d_resp_data  = r_d_resp_data;
endmodule
